gauss_sched: RTL

Row-sequencing controller for the 3x3 Gaussian column datapath (`gauss`) in the Canny front end. It accepts a raster pixel stream and stores rows in a 3-row rotating line buffer. For each row from row 2 onward, it replays the three vertically aligned columns to the `gauss` inputs as one contiguous burst. Because the `gauss` pipeline has no stall or valid, the block tracks each column through that pipeline and tags every filtered output with its valid flag and image coordinates.

---
 rtl/gauss_sched.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/gauss_sched.sv
// Row sequencer for the 3x3 Gaussian column datapath: buffers raster rows in a
// 3-row rotating line store, replays aligned columns as bursts and tags results.
module gauss_sched #(
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 64,
    parameter int GAUSS_LAT = 6,
    parameter int XW        = $clog2(IMG_W),
    parameter int YW        = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    pix_in,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic [7:0]    g_in0,
    output logic [7:0]    g_in1,
    output logic [7:0]    g_in2,
    output logic          out_valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_BURST = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);
    localparam logic [XW-1:0] C_TWO  = XW'(2);

    state_t        state_r;
    state_t        state_s;
    logic [XW-1:0] x_r;
    logic [XW-1:0] x_s;
    logic [YW-1:0] y_r;
    logic [YW-1:0] y_s;
    logic [XW-1:0] c_r;
    logic [XW-1:0] c_s;
    logic [1:0]    slot_r;
    logic [1:0]    slot_s;
    logic [1:0]    slot_inc_s;
    logic [1:0]    slot_m1_s;
    logic [1:0]    slot_m2_s;
    logic          done_s;
    logic          accept_s;
    logic          upstream_busy_s;

    logic          pix_ready_r;
    logic [7:0]    g0_r;
    logic [7:0]    g1_r;
    logic [7:0]    g2_r;
    logic          frame_done_r;

    logic [7:0]    line_mem [3][IMG_W];

    logic          tag_v_r [GAUSS_LAT];
    logic [XW-1:0] tag_x_r [GAUSS_LAT];
    logic [YW-1:0] tag_y_r [GAUSS_LAT];

    assign accept_s   = pix_valid && pix_ready_r;
    assign pix_ready  = pix_ready_r;
    assign g_in0      = g0_r;
    assign g_in1      = g1_r;
    assign g_in2      = g2_r;
    assign frame_done = frame_done_r;
    assign out_valid  = tag_v_r[GAUSS_LAT-1];
    assign out_x      = tag_x_r[GAUSS_LAT-1];
    assign out_y      = tag_y_r[GAUSS_LAT-1];

    // Buffer slot arithmetic: slot_r is always y mod 3, so the older rows sit one and two slots back.
    always_comb begin
        slot_inc_s = (slot_r == 2'd2) ? 2'd0 : slot_r + 2'd1;
        slot_m1_s  = (slot_r == 2'd0) ? 2'd2 : slot_r - 2'd1;
        case (slot_r)
            2'd0:    slot_m2_s = 2'd1;
            2'd1:    slot_m2_s = 2'd2;
            default: slot_m2_s = 2'd0;
        endcase
    end

    // DRAIN may finish once every tag except the last stage is empty, so the pulse trails the final result.
    always_comb begin
        upstream_busy_s = 1'b0;
        for (int i = 0; i < GAUSS_LAT - 1; i++) begin
            upstream_busy_s = upstream_busy_s | tag_v_r[i];
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        c_s     = c_r;
        slot_s  = slot_r;
        done_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_FILL;
                    x_s     = '0;
                    y_s     = '0;
                    slot_s  = 2'd0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FILL: begin
                if (accept_s) begin
                    if (x_r == X_LAST) begin
                        x_s = '0;
                        if (y_r < Y_TWO) begin
                            y_s    = y_r + YW'(1);
                            slot_s = slot_inc_s;
                        end else begin
                            state_s = S_BURST;
                            c_s     = '0;
                        end
                    end else begin
                        x_s = x_r + XW'(1);
                    end
                end else begin
                    state_s = S_FILL;
                end
            end
            S_BURST: begin
                if (c_r == X_LAST) begin
                    if (y_r < Y_LAST) begin
                        state_s = S_FILL;
                        y_s     = y_r + YW'(1);
                        x_s     = '0;
                        slot_s  = slot_inc_s;
                    end else begin
                        state_s = S_DRAIN;
                    end
                end else begin
                    c_s = c_r + XW'(1);
                end
            end
            S_DRAIN: begin
                if (!upstream_busy_s) begin
                    state_s = S_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Line store write port; contents are never read before being rewritten, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rst && accept_s) begin
            line_mem[slot_r][x_r] <= pix_in;
        end
    end

    // Control registers and column outputs; the column for the next cycle is fetched one edge early.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            x_r          <= '0;
            y_r          <= '0;
            c_r          <= '0;
            slot_r       <= 2'd0;
            pix_ready_r  <= 1'b0;
            g0_r         <= 8'd0;
            g1_r         <= 8'd0;
            g2_r         <= 8'd0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            x_r          <= x_s;
            y_r          <= y_s;
            c_r          <= c_s;
            slot_r       <= slot_s;
            pix_ready_r  <= (state_s == S_FILL);
            frame_done_r <= done_s;
            if (state_s == S_BURST) begin
                g0_r <= line_mem[slot_m2_s][c_s];
                g1_r <= line_mem[slot_m1_s][c_s];
                g2_r <= line_mem[slot_r][c_s];
            end else begin
                g0_r <= 8'd0;
                g1_r <= 8'd0;
                g2_r <= 8'd0;
            end
        end
    end

    // Tag pipeline mirroring the gauss latency; columns 0 and 1 only prime the window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < GAUSS_LAT; i++) begin
                tag_v_r[i] <= 1'b0;
                tag_x_r[i] <= '0;
                tag_y_r[i] <= '0;
            end
        end else begin
            if (state_r == S_BURST) begin
                tag_v_r[0] <= (c_r >= C_TWO);
                tag_x_r[0] <= c_r - XW'(1);
                tag_y_r[0] <= y_r - YW'(1);
            end else begin
                tag_v_r[0] <= 1'b0;
                tag_x_r[0] <= '0;
                tag_y_r[0] <= '0;
            end
            for (int i = 1; i < GAUSS_LAT; i++) begin
                tag_v_r[i] <= tag_v_r[i-1];
                tag_x_r[i] <= tag_x_r[i-1];
                tag_y_r[i] <= tag_y_r[i-1];
            end
        end
    end

endmodule
